fifo_port_arbiter: RTL and testbench

Arbitrates a single-port 16x8 FIFO buffer between one write requester and one read requester, performing at most one memory operation per cycle. Contended cycles are resolved with alternating priority. The block tracks occupancy, blocks writes when full and reads when empty, and reports sticky overflow and underflow attempts. It holds its own storage array, exposes the pointers for debug, and can idle on cycles with no request.

---
 rtl/fifo_port_arbiter_if.sv | 34 +++
 rtl/fifo_port_arbiter.sv | 97 +++++++++
 tb/tb_fifo_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_port_arbiter_if.sv
// Request, grant, data and status bundle between the FIFO port arbiter and its two requesters.
interface fifo_port_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          flush;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic          err_clr;
  logic          ovf_err;
  logic          unf_err;

  modport master (
    output flush, wr_req, wr_data, rd_req, err_clr,
    input  wr_ack, rd_ack, rd_data, rd_valid, count, full, empty,
           waddr, raddr, ovf_err, unf_err
  );

  modport slave (
    input  flush, wr_req, wr_data, rd_req, err_clr,
    output wr_ack, rd_ack, rd_data, rd_valid, count, full, empty,
           waddr, raddr, ovf_err, unf_err
  );
endinterface

// File: rtl/fifo_port_arbiter.sv
// Single-port FIFO buffer shared by one writer and one reader; one memory access per cycle,
// alternating priority on contention, occupancy tracking and sticky overflow/underflow flags.
module fifo_port_arbiter #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input logic               clk,
  input logic               rst,
  fifo_port_arbiter_if.slave bus
);
  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic {PRI_WR = 1'b0, PRI_RD = 1'b1} pri_t;

  pri_t          pri;
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   count;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          ovf_err;
  logic          unf_err;
  logic          full;
  logic          empty;
  logic          we;
  logic          re;
  logic          wr_ack;
  logic          rd_ack;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  assign we = bus.wr_req & ~full  & ~bus.flush;
  assign re = bus.rd_req & ~empty & ~bus.flush;

  // On contention the side named by pri wins; the two grants are mutually exclusive.
  assign wr_ack = we & (~re | (pri == PRI_WR));
  assign rd_ack = re & (~we | (pri == PRI_RD));

  always_ff @(posedge clk) begin
    if (wr_ack) mem[waddr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pri      <= PRI_WR;
      count    <= '0;
      waddr    <= '0;
      raddr    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ovf_err  <= 1'b0;
      unf_err  <= 1'b0;
    end else begin
      rd_valid <= rd_ack;
      if (we && re) pri <= (pri == PRI_WR) ? PRI_RD : PRI_WR;

      if (bus.flush) begin
        count <= '0;
        waddr <= '0;
        raddr <= '0;
      end else begin
        if (wr_ack) begin
          waddr <= waddr + PTR_ONE;
          count <= count + CNT_ONE;
        end
        if (rd_ack) begin
          rd_data <= mem[raddr];
          raddr   <= raddr + PTR_ONE;
          count   <= count - CNT_ONE;
        end
      end

      // A new error in the same cycle beats err_clr; a flush cycle never flags errors.
      if (bus.wr_req && full && !bus.flush) ovf_err <= 1'b1;
      else if (bus.err_clr)                 ovf_err <= 1'b0;
      if (bus.rd_req && empty && !bus.flush) unf_err <= 1'b1;
      else if (bus.err_clr)                  unf_err <= 1'b0;
    end
  end

  assign bus.wr_ack   = wr_ack;
  assign bus.rd_ack   = rd_ack;
  assign bus.rd_data  = rd_data;
  assign bus.rd_valid = rd_valid;
  assign bus.count    = count;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.waddr    = waddr;
  assign bus.raddr    = raddr;
  assign bus.ovf_err  = ovf_err;
  assign bus.unf_err  = unf_err;
endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Scenario-driven bench for fifo_port_arbiter; written data goes into a scoreboard queue
// and is popped and compared whenever the DUT presents rd_valid.
module tb_fifo_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic wa, ra;
  logic [7:0] sb[$];

  fifo_port_arbiter_if #(.DW(8), .AW(4)) bus ();

  fifo_port_arbiter #(.DW(8), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Scoreboard: every rd_valid must match the oldest granted write.
  always @(negedge clk) begin
    if (!rst && bus.rd_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_data: rd_valid with empty scoreboard, rd_data=%h", bus.rd_data);
      end else begin
        logic [7:0] exp_d;
        exp_d = sb.pop_front();
        if (bus.rd_data !== exp_d) begin
          errors++;
          $display("FAIL sb_data: got %h expected %h", bus.rd_data, exp_d);
        end
      end
    end
  end

  // One clock of stimulus: acks are captured just before the edge, registered outputs
  // are settled on return.
  task automatic drive(input logic w, input logic [7:0] wd, input logic r,
                       input logic f, input logic c);
    @(negedge clk);
    bus.wr_req  = w;
    bus.wr_data = wd;
    bus.rd_req  = r;
    bus.flush   = f;
    bus.err_clr = c;
    #1;
    wa = bus.wr_ack;
    ra = bus.rd_ack;
    if (wa === 1'b1) sb.push_back(wd);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.wr_req = 0; bus.wr_data = 0; bus.rd_req = 0; bus.flush = 0; bus.err_clr = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.count, bus.full, bus.empty, bus.waddr, bus.raddr, bus.rd_valid,
         bus.rd_data, bus.ovf_err, bus.unf_err, bus.wr_ack, bus.rd_ack} !==
        {5'd0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset: count=%0d full=%b empty=%b waddr=%0d raddr=%0d rv=%b rd=%h ovf=%b unf=%b required 0/0/1/0/0/0/00/0/0",
               bus.count, bus.full, bus.empty, bus.waddr, bus.raddr, bus.rd_valid,
               bus.rd_data, bus.ovf_err, bus.unf_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      drive(1, 8'h10 + 8'(i), 0, 0, 0);
      checks++;
      if (wa !== 1'b1 || ra !== 1'b0) begin
        errors++;
        $display("FAIL fill_ack[%0d]: wr_ack=%b rd_ack=%b required 1/0", i, wa, ra);
      end
    end
    checks++;
    if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.waddr !== 4'd0) begin
      errors++;
      $display("FAIL fill_state: count=%0d full=%b waddr=%0d required 16/1/0", bus.count, bus.full, bus.waddr);
    end
    drive(1, 8'hEE, 0, 0, 0);
    checks++;
    if (wa !== 1'b0 || bus.ovf_err !== 1'b1 || bus.count !== 5'd16) begin
      errors++;
      $display("FAIL overflow: wr_ack=%b ovf=%b count=%0d required 0/1/16", wa, bus.ovf_err, bus.count);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 1, 0, 0);
      checks++;
      if (ra !== 1'b1 || bus.rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL drain[%0d]: rd_ack=%b rd_valid=%b required 1/1", i, ra, bus.rd_valid);
      end
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
      errors++;
      $display("FAIL drain_empty: empty=%b count=%0d required 1/0", bus.empty, bus.count);
    end
    drive(0, 0, 1, 0, 0);
    checks++;
    if (ra !== 1'b0 || bus.unf_err !== 1'b1 || bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h1F) begin
      errors++;
      $display("FAIL underflow: rd_ack=%b unf=%b rv=%b rd_data=%h required 0/1/0/1f",
               ra, bus.unf_err, bus.rd_valid, bus.rd_data);
    end
    drive(0, 0, 0, 0, 1);
    checks++;
    if (bus.ovf_err !== 1'b0 || bus.unf_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: ovf=%b unf=%b required 0/0", bus.ovf_err, bus.unf_err);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_contend();
    logic [4:0] exp_cnt;
    for (int i = 0; i < 4; i++) drive(1, 8'h40 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(1, 8'h50 + 8'(i), 1, 0, 0);
      exp_cnt = (i % 2 == 0) ? 5'd5 : 5'd4;
      checks++;
      if (wa !== (i % 2 == 0) || ra !== (i % 2 == 1) || bus.count !== exp_cnt) begin
        errors++;
        $display("FAIL contend[%0d]: wr_ack=%b rd_ack=%b count=%0d required %b/%b/%0d",
                 i, wa, ra, bus.count, (i % 2 == 0), (i % 2 == 1), exp_cnt);
      end
    end
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    checks++;
    if (bus.empty !== 1'b1 || bus.waddr !== 4'd7 || bus.raddr !== 4'd7) begin
      errors++;
      $display("FAIL contend_end: empty=%b waddr=%0d raddr=%0d required 1/7/7", bus.empty, bus.waddr, bus.raddr);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 12; i++) drive(1, 8'h80 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, 8'h90 + 8'(i), 0, 0, 0);
    checks++;
    if (bus.count !== 5'd12 || bus.waddr !== 4'd13 || bus.raddr !== 4'd1) begin
      errors++;
      $display("FAIL wrap: count=%0d waddr=%0d raddr=%0d required 12/13/1", bus.count, bus.waddr, bus.raddr);
    end
    for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0);
  endtask

  task automatic test_flush();
    checks++;
    if (bus.count !== 5'd7) begin
      errors++;
      $display("FAIL flush_pre: count=%0d required 7", bus.count);
    end
    drive(1, 8'hCC, 1, 1, 0);
    sb.delete();
    checks++;
    if (wa !== 1'b0 || ra !== 1'b0) begin
      errors++;
      $display("FAIL flush_ack: wr_ack=%b rd_ack=%b required 0/0", wa, ra);
    end
    checks++;
    if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.waddr !== 4'd0 || bus.raddr !== 4'd0 ||
        bus.rd_valid !== 1'b0 || bus.ovf_err !== 1'b0 || bus.unf_err !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: count=%0d empty=%b waddr=%0d raddr=%0d rv=%b ovf=%b unf=%b required 0/1/0/0/0/0/0",
               bus.count, bus.empty, bus.waddr, bus.raddr, bus.rd_valid, bus.ovf_err, bus.unf_err);
    end
    drive(0, 0, 1, 1, 0);
    checks++;
    if (bus.unf_err !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_err: unf=%b required 0", bus.unf_err);
    end
  endtask

  task automatic test_err();
    drive(0, 0, 1, 0, 1);
    checks++;
    if (ra !== 1'b0 || bus.unf_err !== 1'b1) begin
      errors++;
      $display("FAIL err_set_wins: rd_ack=%b unf=%b required 0/1", ra, bus.unf_err);
    end
    drive(0, 0, 0, 0, 1);
    checks++;
    if (bus.unf_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clr: unf=%b required 0", bus.unf_err);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 8'hA5, 1, 0, 0);
    checks++;
    if (wa !== 1'b1 || ra !== 1'b0 || bus.unf_err !== 1'b1) begin
      errors++;
      $display("FAIL no_bypass: wr_ack=%b rd_ack=%b unf=%b required 1/0/1", wa, ra, bus.unf_err);
    end
    drive(0, 0, 1, 0, 1);
    checks++;
    if (ra !== 1'b1 || bus.rd_valid !== 1'b1 || bus.unf_err !== 1'b0) begin
      errors++;
      $display("FAIL next_cycle_read: rd_ack=%b rv=%b unf=%b required 1/1/0", ra, bus.rd_valid, bus.unf_err);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    drive(1, 8'h33, 0, 0, 0);
    drive(1, 8'h34, 0, 0, 0);
    @(negedge clk);
    bus.wr_req  = 1'b1;
    bus.wr_data = 8'h35;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.count !== 5'd0 || bus.waddr !== 4'd0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: count=%0d waddr=%0d empty=%b required 0/0/1", bus.count, bus.waddr, bus.empty);
    end
    sb.delete();
    @(posedge clk);
    #1;
    checks++;
    if (bus.count !== 5'd0 || bus.waddr !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold: count=%0d waddr=%0d required 0/0", bus.count, bus.waddr);
    end
    @(negedge clk);
    bus.wr_req = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_contend();
    test_wrap();
    test_flush();
    test_err();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
